instr_fetch: RTL and testbench

//  Instruction fetch stage (q1). Owns the PC, issues in-order requests to the instruction memory port,

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetch-queue slot: request PC, returned word, and whether the word has arrived
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Ring of fetch entries. A slot is allocated when its request is accepted, filled when its word
// returns (in order), and popped from the head once filled. Flush empties the ring.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_instr,
  input  logic            pop,
  input  logic            flush,
  output fetch_entry_t    head,
  output logic [AW:0]     alloc_cnt,
  output logic [AW:0]     unfilled_cnt
);

  fetch_entry_t entries [FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0] alloc_ptr;
  logic [AW:0] fill_ptr;
  logic [AW:0] head_ptr;

  assign head         = entries[head_ptr[AW-1:0]];
  assign alloc_cnt    = alloc_ptr - head_ptr;
  assign unfilled_cnt = alloc_ptr - fill_ptr;

  // Slot and pointer updates; alloc, fill and pop always address distinct slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) entries[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) entries[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
    end else begin
      if (alloc) begin
        entries[alloc_ptr[AW-1:0]] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        entries[fill_ptr[AW-1:0]].instr  <= fill_instr;
        entries[fill_ptr[AW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) begin
        entries[head_ptr[AW-1:0]].filled <= 1'b0;
        head_ptr <= head_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests, buffers returned words
// in fetch_queue and hands {instr, pc, pc+4} downstream with valid/ready. A redirect flushes all
// younger fetches; responses still in flight for them are counted in drop_cnt_q and discarded.
// Optional build macro FETCH_PERF_CNT_EN adds delivered-instruction and bubble counters.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_bubble,
`endif
  output logic [31:0] o_pc_incr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] drop_cnt_q;
  fetch_entry_t    head;
  logic [AW:0]     alloc_cnt;
  logic [AW:0]     unfilled_cnt;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            pop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  // Credits are reserved at request time, so a response always has a slot waiting
  assign o_imem_req_valid = !i_rst && !i_redirect_valid && (alloc_cnt < DEPTH_CNT);
  assign o_imem_addr      = pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  // Stale words from flushed requests arrive first, so they are consumed before any fill
  assign rsp_drop = i_imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_fill = i_imem_rsp_valid && (drop_cnt_q == '0) && (unfilled_cnt != '0);

  assign o_valid   = head.filled && !i_redirect_valid;
  assign pop       = o_valid && i_ready;
  assign o_instr   = o_valid ? head.instr : NOP_INSTR;
  assign o_pc      = o_valid ? head.pc : '0;
  assign o_pc_incr = o_valid ? head.pc + 32'd4 : '0;

  fetch_queue #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_queue (
    .clk         (i_clk),
    .rst         (i_rst),
    .alloc       (req_fire),
    .alloc_pc    (pc_q),
    .fill        (rsp_fill),
    .fill_instr  (i_imem_rsp_data),
    .pop         (pop),
    .flush       (i_redirect_valid),
    .head        (head),
    .alloc_cnt   (alloc_cnt),
    .unfilled_cnt(unfilled_cnt)
  );

  // PC and drop-count bookkeeping; a redirect overrides every same-cycle event
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else if (i_redirect_valid) begin
      pc_q       <= {i_redirect_pc[31:2], 2'b00};
      drop_cnt_q <= drop_cnt_q + XLEN'(unfilled_cnt) - XLEN'(rsp_drop || rsp_fill);
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      if (rsp_drop) drop_cnt_q <= drop_cnt_q - 32'd1;
    end
  end

  // A response must always match a dropped or an unfilled request
  assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rsp_valid |-> (drop_cnt_q != '0 || unfilled_cnt != '0));

`ifdef FETCH_PERF_CNT_EN
  // Delivered instructions and cycles where downstream was ready but starved
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_fetched <= '0;
      o_perf_bubble  <= '0;
    end else begin
      if (pop) o_perf_fetched <= o_perf_fetched + 32'd1;
      if (i_ready && !o_valid) o_perf_bubble <= o_perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with random latency and an epoch-based reference
// that expects a sequential PC stream restarting at each redirect target.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned DEPTH  = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_incr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_perf_fetched;
  logic [31:0] o_perf_bubble;
`endif

  instr_fetch #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_addr     (o_imem_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data (i_imem_rsp_data),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
`ifdef FETCH_PERF_CNT_EN
    .o_perf_fetched  (o_perf_fetched),
    .o_perf_bubble   (o_perf_bubble),
`endif
    .o_pc_incr       (o_pc_incr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } pend_t;

  pend_t       pend[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned lat_max = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  int          live;
  int          avail;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_deliv = 0;
  int unsigned m_fetched = 0;
  int unsigned m_bubble = 0;
  logic        last_valid;
  logic [31:0] last_pc;
  logic [31:0] last_incr;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // One clock cycle: drive inputs at the negedge, check against the model, advance the model
  task automatic cycle(input logic rdy, input logic mrdy, input logic redir,
                       input logic [31:0] rpc);
    logic        acc, pp, rsp_cur, exp_v, exp_rv;
    logic [31:0] acc_addr;
    i_ready          = rdy;
    i_imem_req_ready = mrdy;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    rsp_cur          = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(pend[0].addr);
      rsp_cur          = (pend[0].epoch == epoch);
      pend.delete(0);
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom;
    end
    #1;
    exp_v  = !redir && (avail > 0);
    exp_rv = !redir && (live < int'(DEPTH));
    n_cmp++;
    if (o_valid !== exp_v) begin
      n_bad++;
      $display("FAIL o_valid cyc=%0d got %b want %b", cyc, o_valid, exp_v);
    end
    n_cmp++;
    if (o_imem_req_valid !== exp_rv) begin
      n_bad++;
      $display("FAIL req_valid cyc=%0d got %b want %b", cyc, o_imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      n_cmp++;
      if (o_imem_addr !== exp_fetch) begin
        n_bad++;
        $display("FAIL imem_addr cyc=%0d got %h want %h", cyc, o_imem_addr, exp_fetch);
      end
    end
    if (exp_v) begin
      n_cmp++;
      if (o_pc !== exp_pc) begin
        n_bad++;
        $display("FAIL o_pc cyc=%0d got %h want %h", cyc, o_pc, exp_pc);
      end
      n_cmp++;
      if (o_instr !== mem_word(exp_pc)) begin
        n_bad++;
        $display("FAIL o_instr cyc=%0d got %h want %h", cyc, o_instr, mem_word(exp_pc));
      end
      n_cmp++;
      if (o_pc_incr !== exp_pc + 32'd4) begin
        n_bad++;
        $display("FAIL o_pc_incr cyc=%0d got %h want %h", cyc, o_pc_incr, exp_pc + 32'd4);
      end
    end else begin
      n_cmp++;
      if (o_instr !== NOP_INSTR) begin
        n_bad++;
        $display("FAIL nop cyc=%0d got %h want %h", cyc, o_instr, NOP_INSTR);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (o_perf_fetched !== m_fetched) begin
      n_bad++;
      $display("FAIL perf_fetched cyc=%0d got %0d want %0d", cyc, o_perf_fetched, m_fetched);
    end
    n_cmp++;
    if (o_perf_bubble !== m_bubble) begin
      n_bad++;
      $display("FAIL perf_bubble cyc=%0d got %0d want %0d", cyc, o_perf_bubble, m_bubble);
    end
`endif
    last_valid = o_valid;
    last_pc    = o_pc;
    last_incr  = o_pc_incr;
    last_addr  = o_imem_addr;
    acc        = o_imem_req_valid && mrdy;
    acc_addr   = o_imem_addr;
    pp         = o_valid && rdy;
    if (rdy && !o_valid) m_bubble++;
    if (pp) begin
      m_fetched++;
      n_deliv++;
    end
    @(posedge i_clk);
    if (acc) pend.push_back('{addr: acc_addr, due: cyc + 1 + $urandom_range(0, lat_max),
                              epoch: epoch});
    if (redir) begin
      epoch++;
      live      = 0;
      avail     = 0;
      exp_pc    = {rpc[31:2], 2'b00};
      exp_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (rsp_cur) avail++;
      if (pp) begin
        avail--;
        live--;
        exp_pc = exp_pc + 32'd4;
      end
      if (acc) begin
        live++;
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_rst            = 1'b1;
    i_ready          = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    pend.delete();
    epoch++;
    live      = 0;
    avail     = 0;
    exp_pc    = RST_PC;
    exp_fetch = RST_PC;
    m_fetched = 0;
    m_bubble  = 0;
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  // Run until a valid instruction is presented; an expired budget is a failure
  task automatic wait_valid(input string name, input logic rdy);
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cycle(rdy, 1'b1, 1'b0, '0);
      seen = last_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout got no o_valid want o_valid", name);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", o_valid); end
    n_cmp++;
    if (o_imem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_req got %b want 0", o_imem_req_valid);
    end
    n_cmp++;
    if (o_instr !== NOP_INSTR) begin n_bad++; $display("FAIL rst_instr got %h want nop", o_instr); end
    n_cmp++;
    if (o_pc !== 32'd0 || o_pc_incr !== 32'd0) begin
      n_bad++; $display("FAIL rst_pc got %h/%h want 0/0", o_pc, o_pc_incr);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_sequential();
    int unsigned d0 = n_deliv;
    lat_max = 0;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b0, '0);
    // Two-cycle startup, then one instruction per cycle
    n_cmp++;
    if (n_deliv - d0 !== 8) begin
      n_bad++; $display("FAIL seq_throughput got %0d want 8", n_deliv - d0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    cycle(1'b0, 1'b1, 1'b0, '0);
    pc0 = last_pc;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (last_pc !== pc0) begin n_bad++; $display("FAIL stall_pc got %h want %h", last_pc, pc0); end
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic test_redirect_inflight();
    lat_max = 3;
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0403);
    lat_max = 0;
    wait_valid("inflight", 1'b0);
    n_cmp++;
    if (last_pc !== 32'h0000_0400) begin
      n_bad++; $display("FAIL inflight_pc got %h want 00000400", last_pc);
    end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] tgt = {$urandom_range(32'h100, 32'hFFFF), 2'b00};
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, tgt);
    n_cmp++;
    if (last_valid !== 1'b0) begin n_bad++; $display("FAIL collide_valid got 1 want 0"); end
    wait_valid("collide", 1'b1);
    n_cmp++;
    if (last_pc !== tgt) begin n_bad++; $display("FAIL collide_pc got %h want %h", last_pc, tgt); end
  endtask

  task automatic test_wrap();
    logic [31:0] a0;
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 1'b0, '0);
    a0 = last_addr;
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (last_addr !== a0 || a0 !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_hold got %h/%h want fffffffc", a0, last_addr);
    end
    wait_valid("wrap", 1'b0);
    n_cmp++;
    if (last_pc !== 32'hFFFF_FFFC || last_incr !== 32'd0) begin
      n_bad++; $display("FAIL wrap_incr got %h/%h want fffffffc/0", last_pc, last_incr);
    end
    cycle(1'b1, 1'b1, 1'b0, '0);
    wait_valid("wrap_next", 1'b0);
    n_cmp++;
    if (last_pc !== 32'd0) begin n_bad++; $display("FAIL wrap_next got %h want 0", last_pc); end
  endtask

  task automatic test_random();
    lat_max = 2;
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom);
    end
    lat_max = 0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    i_rst = 1'b0;
    for (int k = 0; k < 16; k++) cycle((k % 5) != 4, 1'b1, 1'b0, '0);
    // Asynchronous reset in the middle of a cycle clears everything without a clock edge
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_perf_fetched !== 32'd0 || o_perf_bubble !== 32'd0) begin
      n_bad++; $display("FAIL perf_async got %0d/%0d want 0/0", o_perf_fetched, o_perf_bubble);
    end
    n_cmp++;
    if (o_valid !== 1'b0 || o_instr !== NOP_INSTR || o_imem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL async_out got %b/%h/%b want 0/nop/0", o_valid, o_instr,
                        o_imem_req_valid);
    end
    apply_reset();
    i_rst = 1'b0;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b0, '0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
